// File: rtl/sample_stream_reader.sv
// Read-side consumer for the sample generator: strobes reads, captures words
// after a fixed latency, buffers them and checks the test-mode sequence.
module sample_stream_reader #(
  parameter int          READ_LATENCY = 2,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] TEST_STEP    = 16'd64
) (
  input  logic        inclk,
  input  logic        nReset,
  input  logic        collectData,
  input  logic        testMode,
  input  logic        dataAvailable,
  input  logic [15:0] dataIn,
  output logic        readData,
  output logic [15:0] dataOut,
  output logic        dataValid,
  input  logic        dataReady,
  output logic [6:0]  fifoLevel,
  output logic        sequenceError,
  output logic [15:0] errorCount,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [READ_LATENCY-1:0] pipe_q;
  logic [2:0]              in_flight;
  logic [AW-1:0]           wptr_q, rptr_q;
  logic [6:0]              level_q;
  logic [15:0]             mem_q [FIFO_DEPTH];
  logic [15:0]             ref_q;
  logic                    ref_vld_q;
  logic                    seq_err_q;
  logic [15:0]             err_cnt_q;
  logic                    ovf_q;

  logic capture, pop, full, push, start, mismatch;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + 3'(pipe_q[i]);
    end
  end

  assign capture  = pipe_q[READ_LATENCY-1];
  assign dataValid = (level_q != '0);
  assign pop      = dataValid && dataReady;
  assign full     = (level_q == 7'(FIFO_DEPTH));
  assign push     = capture && (!full || pop);
  assign start    = (state_q == IDLE) && collectData;
  assign mismatch = capture && testMode && ref_vld_q &&
                    (dataIn != ref_q + TEST_STEP);

  always_comb begin
    state_d  = state_q;
    readData = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (collectData) state_d = RUN;
      end
      RUN: begin
        readData = collectData && dataAvailable &&
                   ((level_q + 7'(in_flight)) < 7'(FIFO_DEPTH));
        if (!collectData) state_d = DRAIN;
      end
      DRAIN: begin
        if (collectData) begin
          state_d = RUN;
        end else if (in_flight == '0 && level_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      pipe_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pipe_q  <= (pipe_q << 1) | READ_LATENCY'(readData);
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop) level_q <= level_q + 7'd1;
      else if (pop && !push) level_q <= level_q - 7'd1;
      if (capture && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: dataOut is forced to zero while empty.
  always_ff @(posedge inclk) begin
    if (push) mem_q[wptr_q] <= dataIn;
  end

  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      ref_q     <= '0;
      ref_vld_q <= 1'b0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else if (start) begin
      ref_vld_q <= 1'b0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else if (capture && testMode) begin
      ref_q     <= dataIn;
      ref_vld_q <= 1'b1;
      if (mismatch) begin
        seq_err_q <= 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign dataOut       = dataValid ? mem_q[rptr_q] : 16'h0000;
  assign fifoLevel     = level_q;
  assign sequenceError = seq_err_q;
  assign errorCount    = err_cnt_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_sample_stream_reader.sv
// Scoreboard bench for sample_stream_reader: a generator model answers read
// strobes, expected words are queued at issue and checked on delivery.
module tb_sample_stream_reader;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        collect = 1'b0;
  logic        tmode = 1'b0;
  logic        avail = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] din = 16'h0;
  logic        rd;
  logic [15:0] dout;
  logic        dv;
  logic [6:0]  lvl;
  logic        serr;
  logic [15:0] ecnt;
  logic        ovf;

  int n_chk = 0;
  int n_err = 0;
  int n_rx  = 0;

  logic [15:0] sb [$];
  logic [15:0] gp [L];
  logic [15:0] gen_val = 16'h0;
  logic [15:0] gw;
  bit          inj_arm = 1'b0;

  always #5 clk = ~clk;

  sample_stream_reader #(
    .READ_LATENCY(L),
    .FIFO_DEPTH(8),
    .TEST_STEP(16'd64)
  ) dut (
    .inclk(clk),
    .nReset(rst_n),
    .collectData(collect),
    .testMode(tmode),
    .dataAvailable(avail),
    .dataIn(din),
    .readData(rd),
    .dataOut(dout),
    .dataValid(dv),
    .dataReady(ready),
    .fifoLevel(lvl),
    .sequenceError(serr),
    .errorCount(ecnt),
    .overflow(ovf)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Generator: a strobe seen before edge k is answered on dataIn at edge k+L.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      for (int i = 0; i < L; i++) gp[i] = 16'h0;
      din = 16'h0;
    end else begin
      din = gp[L-1];
      for (int i = L - 1; i > 0; i--) gp[i] = gp[i-1];
      gp[0] = 16'h0;
      if (rd) begin
        gw = gen_val;
        if (inj_arm && gw == 16'h0FC0) begin
          gw = 16'h1000;
          inj_arm = 1'b0;
        end
        gp[0] = gw;
        sb.push_back(gw);
        gen_val = gw + 16'd64;
      end
    end
  end

  // Monitor: every transfer is compared with the oldest issued word.
  always @(negedge clk) begin
    if (rst_n && dv && ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL stale_word: got %0h expected none", dout);
      end else begin
        check("word", dout, sb.pop_front());
      end
      n_rx++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(int target, int budget);
    int b = 0;
    while (n_rx < target && b < budget) begin
      tick();
      b++;
    end
    check("rx_reached", 32'(n_rx >= target), 1);
  endtask

  task automatic wait_lvl(logic [6:0] target, int budget);
    int b = 0;
    while (lvl != target && b < budget) begin
      tick();
      b++;
    end
    check("lvl_reached", lvl, target);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_rd"}, rd, 0);
    check({tag, "_dv"}, dv, 0);
    check({tag, "_lvl"}, lvl, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_ecnt"}, ecnt, 0);
    check({tag, "_serr"}, serr, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    int lat;
    int base;
    tmode = 1'b1;
    ready = 1'b1;
    avail = 1'b1;
    repeat (3) tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    repeat (2) tick();

    // Continuous stream, latency of first word, 100 ordered words
    gen_val = 16'h0000;
    collect = 1'b1;
    tick();
    check("rd_start", rd, 1);
    lat = 0;
    while (!dv && lat < 10) begin
      tick();
      lat++;
    end
    check("first_valid_lat", lat, L + 1);
    wait_rx(100, 300);
    check("s1_ecnt", ecnt, 0);
    check("s1_serr", serr, 0);

    // Backpressure: FIFO fills to depth, strobes stop, no overflow
    ready = 1'b0;
    repeat (12) tick();
    check("bp_lvl", lvl, 8);
    check("bp_rd", rd, 0);
    check("bp_ovf", ovf, 0);
    check("bp_head", dout, sb[0]);
    tick();
    check("bp_hold", dout, sb[0]);
    base = n_rx;
    ready = 1'b1;
    wait_rx(base + 30, 100);

    collect = 1'b0;
    wait_lvl(7'd0, 40);
    repeat (4) tick();
    check("idle_rd", rd, 0);

    // Injected discontinuity then resynchronised sequence
    gen_val = 16'h0E00;
    inj_arm = 1'b1;
    collect = 1'b1;
    wait_rx(n_rx + 20, 80);
    check("inj_ecnt", ecnt, 1);
    check("inj_serr", serr, 1);

    // Stop with 5 buffered and 2 in flight
    ready = 1'b0;
    wait_lvl(7'd5, 20);
    collect = 1'b0;
    #1;
    check("stop_rd", rd, 0);
    check("stop_outstanding", sb.size(), 7);
    base = n_rx;
    ready = 1'b1;
    wait_rx(base + 7, 30);
    repeat (5) tick();
    check("drain_count", n_rx, base + 7);
    check("drain_lvl", lvl, 0);
    check("drain_rd", rd, 0);
    check("drain_ecnt_kept", ecnt, 1);

    // Restart clears counters; sequence wraps through 16'h0000
    gen_val = 16'hFE00;
    collect = 1'b1;
    tick();
    check("restart_ecnt", ecnt, 0);
    check("restart_serr", serr, 0);
    wait_rx(n_rx + 20, 80);
    check("wrap_ecnt", ecnt, 0);
    check("wrap_serr", serr, 0);

    // Reset mid-stream with FIFO half full
    ready = 1'b0;
    wait_lvl(7'd4, 20);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) tick();
    gen_val = 16'h4000;
    ready = 1'b1;
    rst_n = 1'b1;
    wait_rx(n_rx + 20, 80);
    check("final_ovf", ovf, 0);
    check("final_ecnt", ecnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
